// File: rtl/vga_pkg.sv
// Shared widths, resolution indices and controller state encoding for the VGA timing generator.
package vga_pkg;

    localparam int VGA_MAX_H_WIDTH = 12;
    localparam int VGA_MAX_V_WIDTH = 11;

    typedef enum logic [2:0] {
        RES_640X480   = 3'd0,
        RES_800X600   = 3'd1,
        RES_1024X768  = 3'd2,
        RES_1280X1024 = 3'd3,
        RES_CUSTOM0   = 3'd4,
        RES_CUSTOM1   = 3'd5,
        RES_CUSTOM2   = 3'd6,
        RES_CUSTOM3   = 3'd7
    } resolution_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_LOAD = 3'd3,
        ST_RUN  = 3'd4
    } vga_tg_state_e;

endpackage

// File: rtl/vga_axis_cnt.sv
// One scan axis: position counter with wrap at the programmed total, plus active/sync window decode.
module vga_axis_cnt #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] disp_i,
    input  logic [W-1:0] front_i,
    input  logic [W-1:0] sync_i,
    input  logic [W-1:0] back_i,
    output logic [W+1:0] cnt_o,
    output logic [W+1:0] total_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    logic [W+1:0] cnt_q, cnt_d;
    logic [W+1:0] sync_beg, sync_end;

    // Two extra bits hold the sum of four W-bit fields without overflow.
    always_comb begin
        total_o  = (W+2)'(disp_i) + (W+2)'(front_i) + (W+2)'(sync_i) + (W+2)'(back_i);
        sync_beg = (W+2)'(disp_i) + (W+2)'(front_i);
        sync_end = sync_beg + (W+2)'(sync_i);
        wrap_o   = (cnt_q == total_o - (W+2)'(1));
        active_o = (cnt_q < (W+2)'(disp_i));
        sync_o   = (cnt_q >= sync_beg) && (cnt_q < sync_end);
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + (W+2)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing controller: fetches mode parameters on start, validates them, then scans frames
// producing registered sync/DE/coordinate outputs one cycle behind the counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       start_i,
    input  resolution_e                resolution_i,
    output logic                       req_o,
    output resolution_e                resolution_o,
    input  logic                       valid_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hd_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hf_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hr_i,
    input  logic [VGA_MAX_H_WIDTH-1:0] hb_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vd_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vf_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vr_i,
    input  logic [VGA_MAX_V_WIDTH-1:0] vb_i,
    input  logic [7:0]                 freq_int_i,
    input  logic [7:0]                 freq_frac_i,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       de_o,
    output logic [VGA_MAX_H_WIDTH-1:0] x_o,
    output logic [VGA_MAX_V_WIDTH-1:0] y_o,
    output logic                       frame_start_o,
    output logic [7:0]                 freq_int_o,
    output logic [7:0]                 freq_frac_o,
    output logic                       running_o,
    output logic                       cfg_err_o
);

    localparam int HW = VGA_MAX_H_WIDTH;
    localparam int VW = VGA_MAX_V_WIDTH;

    vga_tg_state_e   state_q, state_d;
    resolution_e     res_q, res_d;
    logic            req_q, req_d, run_q, run_d, err_q, err_d, pend_q, pend_d;
    logic [HW-1:0]   hd_q, hd_d, hf_q, hf_d, hr_q, hr_d, hb_q, hb_d;
    logic [VW-1:0]   vd_q, vd_d, vf_q, vf_d, vr_q, vr_d, vb_q, vb_d;
    logic [7:0]      fi_cap_q, fi_cap_d, ff_cap_q, ff_cap_d;
    logic [7:0]      fi_q, fi_d, ff_q, ff_d;
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [HW-1:0]   x_q, x_d;
    logic [VW-1:0]   y_q, y_d;

    logic            cnt_clr, h_en, v_en;
    logic [HW+1:0]   h_cnt, h_total;
    logic [VW+1:0]   v_cnt, v_total;
    logic            h_wrap, h_act, h_sync, v_wrap, v_act, v_sync;

    assign cnt_clr = (state_q == ST_LOAD);
    assign h_en    = (state_q == ST_RUN);
    assign v_en    = h_en && h_wrap;

    vga_axis_cnt #(.W(HW)) u_h_axis (
        .clk_i(clk_i), .arstn_i(arstn_i), .clr_i(cnt_clr), .en_i(h_en),
        .disp_i(hd_q), .front_i(hf_q), .sync_i(hr_q), .back_i(hb_q),
        .cnt_o(h_cnt), .total_o(h_total), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
    );

    vga_axis_cnt #(.W(VW)) u_v_axis (
        .clk_i(clk_i), .arstn_i(arstn_i), .clr_i(cnt_clr), .en_i(v_en),
        .disp_i(vd_q), .front_i(vf_q), .sync_i(vr_q), .back_i(vb_q),
        .cnt_o(v_cnt), .total_o(v_total), .wrap_o(v_wrap), .active_o(v_act), .sync_o(v_sync)
    );

    always_comb begin
        state_d = state_q; res_d = res_q; err_d = err_q; pend_d = pend_q;
        hd_d = hd_q; hf_d = hf_q; hr_d = hr_q; hb_d = hb_q;
        vd_d = vd_q; vf_d = vf_q; vr_d = vr_q; vb_d = vb_q;
        fi_cap_d = fi_cap_q; ff_cap_d = ff_cap_q; fi_d = fi_q; ff_d = ff_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                res_d   = resolution_i;
                state_d = ST_REQ;
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (valid_i) begin
                hd_d = hd_i; hf_d = hf_i; hr_d = hr_i; hb_d = hb_i;
                vd_d = vd_i; vf_d = vf_i; vr_d = vr_i; vb_d = vb_i;
                fi_cap_d = freq_int_i; ff_cap_d = freq_frac_i;
                state_d  = ST_LOAD;
            end
            ST_LOAD: if (h_total == '0 || v_total == '0 || hd_q == '0 || vd_q == '0) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                err_d   = 1'b0;
                fi_d    = fi_cap_q;
                ff_d    = ff_cap_q;
                state_d = ST_RUN;
            end
            ST_RUN: if (pend_q && h_wrap && v_wrap) begin
                // A restart request only takes effect once the current frame has been fully scanned.
                pend_d  = 1'b0;
                state_d = ST_REQ;
            end else if (start_i) begin
                pend_d = 1'b1;
                res_d  = resolution_i;
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_REQ);
        run_d = (state_d == ST_RUN);

        hs_d = ~HSYNC_POL; vs_d = ~VSYNC_POL; de_d = 1'b0; fs_d = 1'b0; x_d = '0; y_d = '0;
        if (state_q == ST_RUN) begin
            hs_d = h_sync ? HSYNC_POL : ~HSYNC_POL;
            vs_d = v_sync ? VSYNC_POL : ~VSYNC_POL;
            de_d = h_act && v_act;
            fs_d = (h_cnt == '0) && (v_cnt == '0);
            x_d  = h_cnt[HW-1:0];
            y_d  = v_cnt[VW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE; res_q <= RES_640X480;
            req_q <= 1'b0; run_q <= 1'b0; err_q <= 1'b0; pend_q <= 1'b0;
            hd_q <= '0; hf_q <= '0; hr_q <= '0; hb_q <= '0;
            vd_q <= '0; vf_q <= '0; vr_q <= '0; vb_q <= '0;
            fi_cap_q <= '0; ff_cap_q <= '0; fi_q <= '0; ff_q <= '0;
            hs_q <= ~HSYNC_POL; vs_q <= ~VSYNC_POL; de_q <= 1'b0; fs_q <= 1'b0;
            x_q <= '0; y_q <= '0;
        end else begin
            state_q <= state_d; res_q <= res_d;
            req_q <= req_d; run_q <= run_d; err_q <= err_d; pend_q <= pend_d;
            hd_q <= hd_d; hf_q <= hf_d; hr_q <= hr_d; hb_q <= hb_d;
            vd_q <= vd_d; vf_q <= vf_d; vr_q <= vr_d; vb_q <= vb_d;
            fi_cap_q <= fi_cap_d; ff_cap_q <= ff_cap_d; fi_q <= fi_d; ff_q <= ff_d;
            hs_q <= hs_d; vs_q <= vs_d; de_q <= de_d; fs_q <= fs_d;
            x_q <= x_d; y_q <= y_d;
        end
    end

    assign req_o         = req_q;
    assign resolution_o  = res_q;
    assign running_o     = run_q;
    assign cfg_err_o     = err_q;
    assign freq_int_o    = fi_q;
    assign freq_frac_o   = ff_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign de_o          = de_q;
    assign frame_start_o = fs_q;
    assign x_o           = x_q;
    assign y_o           = y_q;

endmodule
